// File: rtl/core_pkg.sv
// core_pkg: shared FSM state, owner encoding and default widths for the memory arbiter.
package core_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU, LSU and memory-port signals; slave is the arbiter view, master the environment view.
interface mem_arbiter_if import core_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
  modport master (
    output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_rdata,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/arb_prio_sel.sv
// arb_prio_sel: LSU-first winner selection, overridden for IFU once the starvation limit is reached.
module arb_prio_sel #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
  input  logic [3:0] starve_cnt_i,
  output logic       grant_ifu_o,
  output logic       grant_lsu_o
);
  logic starved;
  assign starved     = ifu_valid_i && starve_cnt_i == 4'(STARVE_LIMIT);
  assign grant_lsu_o = lsu_valid_i && !starved;
  assign grant_ifu_o = ifu_valid_i && !grant_lsu_o;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU, one outstanding transaction at a time.
module mem_arbiter import core_pkg::*; #(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int MASK_W = DATA_W / 8;
  state_t              state_q, state_d;
  owner_t              owner_q;
  logic [3:0]          starve_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q, ifu_data_q, lsu_data_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                grant_ifu, grant_lsu, idle, accept;
  arb_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .ifu_valid_i (bus.ifu_req_valid),
    .lsu_valid_i (bus.lsu_req_valid),
    .starve_cnt_i(starve_q),
    .grant_ifu_o (grant_ifu),
    .grant_lsu_o (grant_lsu)
  );
  // rst gates the readies so nothing is accepted while reset is held
  assign idle   = state_q == IDLE && !rst;
  assign accept = idle && (grant_ifu || grant_lsu);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept ? REQ : IDLE;
      REQ:  state_d = bus.mem_req_ready ? RESP : REQ;
      RESP: state_d = bus.mem_resp_valid ? DONE : RESP;
      DONE: state_d = IDLE;
    endcase
  end
  assign bus.ifu_req_ready  = idle && grant_ifu;
  assign bus.lsu_req_ready  = idle && grant_lsu;
  assign bus.mem_req_valid  = state_q == REQ;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign bus.ifu_resp_valid = state_q == DONE && owner_q == OWN_IFU;
  assign bus.lsu_resp_valid = state_q == DONE && owner_q == OWN_LSU;
  assign bus.ifu_rdata      = ifu_data_q;
  assign bus.lsu_rdata      = lsu_data_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IFU;
      starve_q   <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      ifu_data_q <= '0;
      lsu_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q  <= grant_lsu ? OWN_LSU : OWN_IFU;
        addr_q   <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
        wen_q    <= grant_lsu && bus.lsu_wen;
        wdata_q  <= grant_lsu ? bus.lsu_wdata : '0;
        wmask_q  <= grant_lsu ? bus.lsu_wmask : '0;
        starve_q <= (grant_lsu && bus.ifu_req_valid) ? starve_q + 4'd1 : 4'd0;
      end
      // each requester keeps its own last response so its rdata holds between its responses
      if (state_q == RESP && bus.mem_resp_valid) begin
        if (owner_q == OWN_LSU) lsu_data_q <= bus.mem_rdata;
        else ifu_data_q <= bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory checked against a transaction-level model.
module tb_mem_arbiter;
  import core_pkg::*;
  localparam int AW = 64, DW = 64, LIM = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    logic        lsu;
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } txn_t;
  int checks = 0, failures = 0;
  txn_t cur;
  int cyc = 0, due = -1, resp_left = 0, starve = 0;
  bit busy, issued, waiting, due_lsu, ifu_acc, lsu_acc, fixed;
  logic [63:0] due_data, ifu_exp, lsu_exp;
  int ifu_p, lsu_p, rdy_p, min_dly, max_dly, spur_p;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic pct(int p);
    return int'($urandom_range(99)) < p;
  endfunction
  task automatic model_reset();
    busy = 0; issued = 0; waiting = 0; due = -1; starve = 0;
    ifu_exp = '0; lsu_exp = '0; ifu_acc = 0; lsu_acc = 0;
  endtask
  task automatic mode(bit f, int ip, int lp, int rp, int mn, int mx, int sp);
    fixed = f; ifu_p = ip; lsu_p = lp; rdy_p = rp; min_dly = mn; max_dly = mx; spur_p = sp;
  endtask
  task automatic check_reset(string tag);
    chk({tag, "_ifu_ready"}, 64'(bus.ifu_req_ready), 64'(0));
    chk({tag, "_lsu_ready"}, 64'(bus.lsu_req_ready), 64'(0));
    chk({tag, "_ifu_resp"}, 64'(bus.ifu_resp_valid), 64'(0));
    chk({tag, "_lsu_resp"}, 64'(bus.lsu_resp_valid), 64'(0));
    chk({tag, "_mem_valid"}, 64'(bus.mem_req_valid), 64'(0));
    chk({tag, "_mem_addr"}, bus.mem_addr, 64'(0));
    chk({tag, "_mem_wen"}, 64'(bus.mem_wen), 64'(0));
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 64'(0));
    chk({tag, "_mem_wmask"}, 64'(bus.mem_wmask), 64'(0));
    chk({tag, "_ifu_rdata"}, bus.ifu_rdata, 64'(0));
    chk({tag, "_lsu_rdata"}, bus.lsu_rdata, 64'(0));
  endtask
  task automatic drive();
    cyc++;
    if (ifu_acc || !bus.ifu_req_valid) begin
      bus.ifu_req_valid = pct(ifu_p);
      bus.ifu_addr = fixed ? 64'h8000_0000 : {32'h0, $urandom} & ~64'h3;
    end
    if (lsu_acc || !bus.lsu_req_valid) begin
      bus.lsu_req_valid = pct(lsu_p);
      bus.lsu_addr  = fixed ? 64'h8000_1000 : {32'h0, $urandom};
      bus.lsu_wen   = fixed ? 1'b1 : 1'($urandom_range(1));
      bus.lsu_wdata = fixed ? 64'h1234_5678_8765_4321 : {$urandom, $urandom};
      bus.lsu_wmask = fixed ? 8'h03 : 8'($urandom_range(255));
    end
    ifu_acc = 0; lsu_acc = 0;
    bus.mem_req_ready = pct(rdy_p);
    bus.mem_resp_valid = 1'b0;
    if (waiting) begin
      if (resp_left == 0) begin
        waiting = 0; due = cyc + 1; due_lsu = cur.lsu;
        due_data = fixed ? 64'h0010_0073 : {$urandom, $urandom};
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = due_data;
      end else resp_left--;
    end else if (pct(spur_p)) begin
      bus.mem_resp_valid = 1'b1; bus.mem_rdata = {$urandom, $urandom};
    end
  endtask
  task automatic sample();
    logic gi, gl, in_req;
    gl = !busy && bus.lsu_req_valid && !(bus.ifu_req_valid && starve == LIM);
    gi = !busy && bus.ifu_req_valid && !gl;
    chk("ifu_req_ready", 64'(bus.ifu_req_ready), 64'(gi));
    chk("lsu_req_ready", 64'(bus.lsu_req_ready), 64'(gl));
    chk("starve_cnt", 64'(dut.starve_q), 64'(starve));
    in_req = busy && !issued;
    chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(in_req));
    if (in_req) begin
      chk("mem_addr", bus.mem_addr, cur.addr);
      chk("mem_wen", 64'(bus.mem_wen), 64'(cur.wen));
      chk("mem_wmask", 64'(bus.mem_wmask), 64'(cur.wmask));
      if (cur.lsu) chk("mem_wdata", bus.mem_wdata, cur.wdata);
      if (bus.mem_req_ready) begin
        issued = 1; waiting = 1; resp_left = int'($urandom_range(max_dly, min_dly));
      end
    end
    chk("ifu_resp_valid", 64'(bus.ifu_resp_valid), 64'(due == cyc && !due_lsu));
    chk("lsu_resp_valid", 64'(bus.lsu_resp_valid), 64'(due == cyc && due_lsu));
    if (due == cyc) begin
      if (due_lsu) lsu_exp = due_data; else ifu_exp = due_data;
      busy = 0; issued = 0;
    end
    chk("ifu_rdata", bus.ifu_rdata, ifu_exp);
    chk("lsu_rdata", bus.lsu_rdata, lsu_exp);
    if (gi || gl) begin
      busy = 1; issued = 0; cur.lsu = gl;
      cur.addr  = gl ? bus.lsu_addr : bus.ifu_addr;
      cur.wen   = gl && bus.lsu_wen;
      cur.wdata = bus.lsu_wdata;
      cur.wmask = gl ? bus.lsu_wmask : 8'h00;
      starve = (gl && bus.ifu_req_valid) ? starve + 1 : 0;
      ifu_acc = gi; lsu_acc = gl;
    end
  endtask
  task automatic step();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask
  task automatic run(int n);
    repeat (n) step();
  endtask
  initial begin
    int n;
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = '0;
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
    model_reset();
    mode(1'b1, 100, 0, 100, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset("init");
    rst = 1'b0;
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    run(20);
    mode(1'b1, 0, 100, 100, 0, 0, 0);
    run(20);
    mode(1'b0, 100, 100, 100, 0, 0, 0);
    run(80);
    mode(1'b0, 60, 60, 15, 0, 2, 0);
    run(300);
    mode(1'b0, 50, 50, 70, 7, 7, 30);
    run(200);
    mode(1'b0, 40, 50, 60, 0, 5, 20);
    run(2000);
    mode(1'b0, 100, 0, 100, 7, 7, 0);
    n = 0;
    while (!(issued && waiting) && n < 100) begin
      step();
      n++;
    end
    chk("reach_resp", 64'(issued && waiting), 64'(1));
    #2;
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
    #1;
    check_reset("rst_resp");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    model_reset();
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 64'hdead_beef_cafe_f00d;
    @(negedge clk);
    chk("late_resp_ifu", 64'(bus.ifu_resp_valid), 64'(0));
    chk("late_resp_lsu", 64'(bus.lsu_resp_valid), 64'(0));
    @(posedge clk);
    #1;
    mode(1'b1, 100, 0, 100, 0, 0, 0);
    run(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
